muxn_rr: RTL and testbench

MUXN_RR -- requirements
Module: muxn_rr

---
 rtl/muxn_rr_if.sv | 24 ++
 rtl/muxn_rr.sv | 79 +++++++
 tb/tb_muxn_rr.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muxn_rr_if.sv
// Stream bundle for muxn_rr: N input channels in, one registered channel out.
interface muxn_rr_if #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
);
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_ready;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_ch;
   logic                    out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/muxn_rr.sv
// N-to-1 stream mux with fixed-select or round-robin grant
// and a single registered output stage.
module muxn_rr #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel,
   muxn_rr_if.slave         bus
);
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] gidx;
   logic [SEL_W-1:0] nxt_ptr;
   logic [SEL_W-1:0] cand;
   logic             found;
   logic             free;
   logic             xfer;
   int               idx;

   assign free = !bus.out_valid || bus.out_ready;

   // Round-robin searches from ptr upward, wrapping at NUM_CH.
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      idx   = 0;
      cand  = '0;
      if (mode) begin
         for (int k = 0; k < NUM_CH; k++) begin
            idx  = (int'(ptr) + k) % NUM_CH;
            cand = SEL_W'(idx);
            if (!found && bus.in_valid[cand]) begin
               found = 1'b1;
               gidx  = cand;
            end
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i) && bus.in_valid[i]) begin
               found = 1'b1;
               gidx  = SEL_W'(i);
            end
         end
      end
   end

   assign bus.in_ready = (found && free && !reset)
                       ? (NUM_CH'(1) << gidx)
                       : '0;

   assign xfer = |bus.in_ready;

   assign nxt_ptr = (gidx == SEL_W'(NUM_CH - 1))
                  ? '0
                  : gidx + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_ch    <= '0;
         ptr           <= '0;
      end else if (free) begin
         if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data[gidx*WIDTH +: WIDTH];
            bus.out_ch    <= gidx;
            if (mode) begin
               ptr <= nxt_ptr;
            end
         end else begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_muxn_rr.sv
// Directed bench for muxn_rr with WIDTH=8, NUM_CH=4.
module tb_muxn_rr;
   logic       clk;
   logic       reset;
   logic       mode;
   logic [1:0] sel;
   int         n_cmp;
   int         n_err;

   muxn_rr_if #(.WIDTH(8), .NUM_CH(4), .SEL_W(2)) bus ();

   muxn_rr #(.WIDTH(8), .NUM_CH(4), .SEL_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .mode  (mode),
      .sel   (sel),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [3:0] exp_rdy;
      reset = 1'b1;
      mode = 1'b1;
      sel = 2'd0;
      bus.in_valid = 4'b1111;
      bus.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rst_valid got=%b exp=0", bus.out_valid);
      end
      n_cmp++;
      if (bus.out_data !== 8'h00) begin
         n_err++;
         $display("FAIL rst_data got=%h exp=00", bus.out_data);
      end
      n_cmp++;
      if (bus.in_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL rst_ready got=%b exp=0000", bus.in_ready);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (bus.in_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL first_grant got=%b exp=0001", bus.in_ready);
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin
         n_err++;
         $display("FAIL first_word got=%b/%h exp=1/11",
                  bus.out_valid, bus.out_data);
      end
      bus.in_valid = 4'b0000;
      bus.out_ready = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
          bus.out_ch !== 2'd0) begin
         n_err++;
         $display("FAIL async_rst got=%b/%h/%0d exp=0/00/0",
                  bus.out_valid, bus.out_data, bus.out_ch);
      end
      reset = 1'b0;
      #1;
      bus.in_valid = 4'b1111;
      bus.out_ready = 1'b1;
      #1;
      exp_rdy = 4'b0001;
      n_cmp++;
      if (bus.in_ready !== exp_rdy) begin
         n_err++;
         $display("FAIL rst_ptr got=%b exp=%b", bus.in_ready, exp_rdy);
      end
      tick();
      n_cmp++;
      if (bus.out_ch !== 2'd0 || bus.out_data !== 8'h11) begin
         n_err++;
         $display("FAIL rst_ptr_word got=%0d/%h exp=0/11",
                  bus.out_ch, bus.out_data);
      end
   endtask

   task automatic test_fixed;
      mode = 1'b0;
      sel = 2'd2;
      bus.in_valid = 4'b1111;
      bus.in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
      bus.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 4'b0100) begin
         n_err++;
         $display("FAIL fixed_ready got=%b exp=0100", bus.in_ready);
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 ||
          bus.out_ch !== 2'd2) begin
         n_err++;
         $display("FAIL fixed_word got=%b/%h/%0d exp=1/a5/2",
                  bus.out_valid, bus.out_data, bus.out_ch);
      end
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_rdy;
      logic [1:0] exp_ch;
      reset = 1'b1;
      #1;
      reset = 1'b0;
      mode = 1'b1;
      bus.in_valid = 4'b1111;
      bus.in_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_ch = 2'(k % 4);
         exp_rdy = 4'b0001 << exp_ch;
         #1;
         n_cmp++;
         if (bus.in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL rr_ready[%0d] got=%b exp=%b",
                     k, bus.in_ready, exp_rdy);
         end
         tick();
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_ch !== exp_ch ||
             bus.out_data !== {6'h30, exp_ch}) begin
            n_err++;
            $display("FAIL rr_word[%0d] got=%b/%0d/%h exp=1/%0d/%h",
                     k, bus.out_valid, bus.out_ch, bus.out_data,
                     exp_ch, {6'h30, exp_ch});
         end
      end
   endtask

   task automatic test_skip_wrap;
      mode = 1'b1;
      bus.in_valid = 4'b1001;
      bus.in_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
      bus.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 4'b1000) begin
         n_err++;
         $display("FAIL skip_ready got=%b exp=1000", bus.in_ready);
      end
      tick();
      n_cmp++;
      if (bus.out_ch !== 2'd3 || bus.out_data !== 8'hD3) begin
         n_err++;
         $display("FAIL skip_word got=%0d/%h exp=3/d3",
                  bus.out_ch, bus.out_data);
      end
      n_cmp++;
      if (bus.in_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL wrap_ready got=%b exp=0001", bus.in_ready);
      end
      tick();
      n_cmp++;
      if (bus.out_ch !== 2'd0 || bus.out_data !== 8'hD0) begin
         n_err++;
         $display("FAIL wrap_word got=%0d/%h exp=0/d0",
                  bus.out_ch, bus.out_data);
      end
   endtask

   task automatic test_mode0_ptr;
      mode = 1'b0;
      sel = 2'd3;
      bus.in_valid = 4'b1111;
      bus.out_ready = 1'b1;
      tick();
      n_cmp++;
      if (bus.out_ch !== 2'd3) begin
         n_err++;
         $display("FAIL m0_ch got=%0d exp=3", bus.out_ch);
      end
      mode = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 4'b0010) begin
         n_err++;
         $display("FAIL m0_ptr got=%b exp=0010", bus.in_ready);
      end
   endtask

   task automatic test_backpressure;
      mode = 1'b0;
      sel = 2'd1;
      bus.in_valid = 4'b0010;
      bus.in_data = {8'h44, 8'h33, 8'h5A, 8'h11};
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid = 4'b1111;
      sel = 2'd2;
      bus.in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++;
         if (bus.in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_ready[%0d] got=%b exp=0000",
                     k, bus.in_ready);
         end
         tick();
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A ||
             bus.out_ch !== 2'd1) begin
            n_err++;
            $display("FAIL bp_hold[%0d] got=%b/%h/%0d exp=1/5a/1",
                     k, bus.out_valid, bus.out_data, bus.out_ch);
         end
      end
      bus.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 4'b0100) begin
         n_err++;
         $display("FAIL bp_release got=%b exp=0100", bus.in_ready);
      end
      tick();
      n_cmp++;
      if (bus.out_data !== 8'hA5 || bus.out_ch !== 2'd2) begin
         n_err++;
         $display("FAIL bp_load got=%h/%0d exp=a5/2",
                  bus.out_data, bus.out_ch);
      end
   endtask

   task automatic test_no_grant;
      mode = 1'b0;
      sel = 2'd3;
      bus.in_valid = 4'b0111;
      bus.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 4'b0000 || bus.out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL ng_ready got=%b/%b exp=0000/1",
                  bus.in_ready, bus.out_valid);
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 8'hA5 ||
          bus.out_ch !== 2'd2) begin
         n_err++;
         $display("FAIL ng_drain got=%b/%h/%0d exp=0/a5/2",
                  bus.out_valid, bus.out_data, bus.out_ch);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_fixed();
      test_round_robin();
      test_skip_wrap();
      test_mode0_ptr();
      test_backpressure();
      test_no_grant();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
